// File: rtl/axis_frame_tx_if.sv
// Descriptor and AXI-stream signal bundle for axis_frame_tx.
// The master modport is the transmitter's view; slave is the source/sink side.
`timescale 1ns/1ps
interface axis_frame_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12
);
  logic [LEN_WIDTH-1:0]  desc_len;
  logic [DATA_WIDTH-1:0] desc_start;
  logic                  desc_user;
  logic                  desc_valid;
  logic                  desc_ready;

  logic [DATA_WIDTH-1:0] output_axis_tdata;
  logic                  output_axis_tvalid;
  logic                  output_axis_tready;
  logic                  output_axis_tlast;
  logic                  output_axis_tuser;

  modport master (
    input  desc_len,
    input  desc_start,
    input  desc_user,
    input  desc_valid,
    output desc_ready,
    output output_axis_tdata,
    output output_axis_tvalid,
    input  output_axis_tready,
    output output_axis_tlast,
    output output_axis_tuser
  );

  modport slave (
    output desc_len,
    output desc_start,
    output desc_user,
    output desc_valid,
    input  desc_ready,
    input  output_axis_tdata,
    input  output_axis_tvalid,
    output output_axis_tready,
    input  output_axis_tlast,
    input  output_axis_tuser
  );
endinterface

// File: rtl/axis_frame_tx.sv
// AXI-stream frame transmitter: one descriptor in, one incrementing-byte frame out.
// Define AXIS_FRAME_TX_GAP_EN to insert GAP_CYCLES idle cycles after every frame.
`timescale 1ns/1ps
module axis_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              async_rst_n,
  axis_frame_tx_if.master   axis,
  output logic              busy,
  output logic [15:0]       frames_sent
);

  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end

`ifdef AXIS_FRAME_TX_GAP_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  user_q, user_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic [15:0]           frames_q, frames_d;

  logic                  desc_ready_c;
  logic                  load_c;
  logic                  xfer_c;
  logic [LEN_WIDTH-1:0]  beat_inc_c;

  // tvalid is exactly "in SEND", so it can never drop before the handshake.
  assign xfer_c     = (state_q == S_SEND) && axis.output_axis_tready;
  assign beat_inc_c = beat_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    user_d       = user_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    frames_d     = frames_q;
`ifdef AXIS_FRAME_TX_GAP_EN
    gap_d        = gap_q;
`endif
    desc_ready_c = 1'b0;
    load_c       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        desc_ready_c = 1'b1;
        load_c       = axis.desc_valid;
      end
      S_SEND: begin
        if (xfer_c) begin
          if (!tlast_q) begin
            beat_d  = beat_inc_c;
            tdata_d = tdata_q + 1'b1;
            tlast_d = (beat_inc_c == len_q);
            tuser_d = user_q & (beat_inc_c == len_q);
          end else begin
            frames_d = frames_q + 16'd1;
`ifdef AXIS_FRAME_TX_GAP_EN
            state_d  = S_GAP;
            gap_d    = GAP_W'(GAP_CYCLES - 1);
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
`else
            // Accepting here lets the next frame follow with no bubble.
            desc_ready_c = 1'b1;
            if (axis.desc_valid) begin
              load_c = 1'b1;
            end else begin
              state_d = S_IDLE;
              tlast_d = 1'b0;
              tuser_d = 1'b0;
            end
`endif
          end
        end
      end
`ifdef AXIS_FRAME_TX_GAP_EN
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (load_c) begin
      state_d = S_SEND;
      len_d   = axis.desc_len;
      user_d  = axis.desc_user;
      beat_d  = '0;
      tdata_d = axis.desc_start;
      tlast_d = (axis.desc_len == '0);
      tuser_d = axis.desc_user & (axis.desc_len == '0);
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      beat_q   <= '0;
      user_q   <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      frames_q <= '0;
`ifdef AXIS_FRAME_TX_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      user_q   <= user_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      frames_q <= frames_d;
`ifdef AXIS_FRAME_TX_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  assign axis.desc_ready         = desc_ready_c;
  assign axis.output_axis_tvalid = (state_q == S_SEND);
  assign axis.output_axis_tdata  = tdata_q;
  assign axis.output_axis_tlast  = tlast_q;
  assign axis.output_axis_tuser  = tuser_q;
  assign busy                    = (state_q != S_IDLE);
  assign frames_sent             = frames_q;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Scoreboard bench for axis_frame_tx: descriptors push expected beats, a negedge
// monitor pops and compares every handshaken beat and checks stall stability.
`timescale 1ns/1ps
module tb_axis_frame_tx;
  localparam int DW  = 8;
  localparam int LW  = 12;
  localparam int GAP = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        async_rst_n = 1'b0;
  logic        busy;
  logic [15:0] frames_sent;

  axis_frame_tx_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  axis_frame_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .axis        (bus.master),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  bit    sb_en = 1'b0;
  int    cyc = 0;
  int    first_hs = -1;
  int    last_hs = -1;
  int    busy_idle = 0;
  bit    stall_prev = 1'b0;
  beat_t prev_beat;
  bit    tready_toggle = 1'b0;
  logic  tready_level = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected completion", name);
  endtask

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    bus.output_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tready_toggle) bus.output_axis_tready = ~bus.output_axis_tready;
      else               bus.output_axis_tready = tready_level;
    end
  end

  // Monitor: signals seen at a negedge are what the next posedge transfers.
  initial begin
    beat_t cur;
    forever begin
      @(negedge clk);
      cyc++;
      if (async_rst_n && sb_en) begin
        cur = {bus.output_axis_tdata, bus.output_axis_tlast, bus.output_axis_tuser};
        if (stall_prev) begin
          chk("stall_tvalid", 32'(bus.output_axis_tvalid), 32'd1);
          chk("stall_hold", 32'(cur), 32'(prev_beat));
        end
        if (bus.output_axis_tvalid && bus.output_axis_tready) begin
          if (exp_q.size() == 0) begin
            timeout("unexpected_beat");
          end else begin
            chk("beat", 32'(cur), 32'(exp_q.pop_front()));
          end
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
        if (busy && !bus.output_axis_tvalid) busy_idle++;
        stall_prev = bus.output_axis_tvalid && !bus.output_axis_tready;
        prev_beat  = cur;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send(input logic [LW-1:0] len, input logic [DW-1:0] start, input logic user);
    beat_t b;
    int    g;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = start + DW'(i);
      b.last = (i == int'(len));
      b.user = user & b.last;
      exp_q.push_back(b);
    end
    bus.desc_len   = len;
    bus.desc_start = start;
    bus.desc_user  = user;
    bus.desc_valid = 1'b1;
    g = 0;
    while (!bus.desc_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) timeout("desc_accept");
    @(negedge clk);
    bus.desc_valid = 1'b0;
    bus.desc_len   = LW'(5);
    bus.desc_start = 8'h5A;
    bus.desc_user  = ~user;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) timeout(name);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int bound;
    bus.desc_len   = '0;
    bus.desc_start = '0;
    bus.desc_user  = 1'b0;
    bus.desc_valid = 1'b0;

    #12;
    chk("rst_tvalid", 32'(bus.output_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(bus.output_axis_tlast), 32'd0);
    chk("rst_tuser", 32'(bus.output_axis_tuser), 32'd0);
    chk("rst_tdata", 32'(bus.output_axis_tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    @(negedge clk);
    async_rst_n = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
    chk("idle_desc_ready", 32'(bus.desc_ready), 32'd1);

    // 1: basic four-beat frame
    send(LW'(3), 8'h10, 1'b0);
    drain("t1_drain");
    chk("t1_frames", 32'(frames_sent), 32'd1);

    // 2: single beat, one cycle after accept
    send(LW'(0), 8'hAA, 1'b1);
    chk("t2_latency_tvalid", 32'(bus.output_axis_tvalid), 32'd1);
    chk("t2_tdata", 32'(bus.output_axis_tdata), 32'hAA);
    chk("t2_tlast_tuser", 32'({bus.output_axis_tlast, bus.output_axis_tuser}), 32'd3);
    drain("t2_drain");
    chk("t2_frames", 32'(frames_sent), 32'd2);

    // 3: data wrap under toggling tready
    tready_toggle = 1'b1;
    send(LW'(2), 8'hFE, 1'b0);
    drain("t3_drain");
    tready_toggle = 1'b0;
    tready_level  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_frames", 32'(frames_sent), 32'd3);

    // 4: back-to-back descriptors
    first_hs  = -1;
    busy_idle = 0;
    send(LW'(1), 8'h20, 1'b0);
    send(LW'(1), 8'h30, 1'b1);
    drain("t4_drain");
`ifdef AXIS_FRAME_TX_GAP_EN
    chk("t4_gap_idle", 32'(busy_idle), 32'(2 * GAP));
`else
    chk("t4_span", 32'(last_hs - first_hs), 32'd3);
    chk("t4_busy_idle", 32'(busy_idle), 32'd0);
`endif
    chk("t4_frames", 32'(frames_sent), 32'd5);

    // 5: asynchronous reset mid-frame with the clock stopped
    send(LW'(7), 8'h40, 1'b1);
    @(negedge clk);
    @(negedge clk);
    sb_en = 1'b0;
    chk("t5_pre_tdata", 32'(bus.output_axis_tdata), 32'h42);
    clk_en = 1'b0;
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", 32'(bus.output_axis_tvalid), 32'd0);
    chk("t5_rst_tlast", 32'(bus.output_axis_tlast), 32'd0);
    chk("t5_rst_tdata", 32'(bus.output_axis_tdata), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_frames", 32'(frames_sent), 32'd0);
    #3;
    async_rst_n = 1'b1;
    #1;
    chk("t5_rel_desc_ready", 32'(bus.desc_ready), 32'd1);
    exp_q.delete();
    clk_en = 1'b1;
    @(negedge clk);
    chk("t5_idle_tvalid", 32'(bus.output_axis_tvalid), 32'd0);
    chk("t5_idle_frames", 32'(frames_sent), 32'd0);

    // 6: frame counter wrap over 65536 single-beat frames
`ifdef AXIS_FRAME_TX_GAP_EN
    bound = 65536 * (GAP + 3) + 100;
`else
    bound = 65536 + 100;
`endif
    n = 0;
    bus.desc_len   = '0;
    bus.desc_start = 8'h00;
    bus.desc_user  = 1'b0;
    bus.desc_valid = 1'b1;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (bus.output_axis_tvalid && bus.output_axis_tready && bus.output_axis_tlast) begin
        n++;
        if (n == 65535) chk("t6_frames_before_last", 32'(frames_sent), 32'hFFFE);
        if (n == 65536) begin
          bus.desc_valid = 1'b0;
          break;
        end
      end
    end
    if (n < 65536) timeout("t6_frames_run");
    bus.desc_valid = 1'b0;
    drain("t6_drain");
    chk("t6_frames_wrap", 32'(frames_sent), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
